// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-domain fill levels,
// programmable almost-full/almost-empty flags and sticky overflow/underflow flags.
module async_fifo_lvl #(
  parameter int G_WIDTH       = 8,
  parameter int G_DEPTH       = 4,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic               i_clk_w,
  input  logic               i_arstN_w,
  input  logic               i_clk_r,
  input  logic               i_arstN_r,
  input  logic               i_wren_w,
  input  logic [G_WIDTH-1:0] i_data_w,
  input  logic [G_DEPTH:0]   i_afull_thr_w,
  input  logic               i_ovf_clr_w,
  output logic               o_full,
  output logic               o_afull_w,
  output logic [G_DEPTH:0]   o_level_w,
  output logic               o_overflow_w,
  input  logic               i_ren_r,
  input  logic [G_DEPTH:0]   i_aempty_thr_r,
  input  logic               i_udf_clr_r,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_empty,
  output logic               o_aempty_r,
  output logic [G_DEPTH:0]   o_level_r,
  output logic               o_underflow_r
);

  localparam int AW = G_DEPTH;
  typedef logic [AW:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [G_WIDTH-1:0] mem [0:(1<<AW)-1];

  // ---------------- write domain ----------------
  ptr_t bin_w, gray_w, bin_w_next, gray_w_next, rd_bin_w, level_w_next, full_cmp;
  logic [G_SYNC_STAGES-1:0][AW:0] rd_sync_w;
  logic wr_acc;

  // Read-side gray pointer, registered in the read domain and synced here.
  ptr_t bin_r, gray_r;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // so no latch can be inferred.
  always_comb begin
    wr_acc       = i_wren_w & ~o_full;
    bin_w_next   = bin_w + {{AW{1'b0}}, wr_acc};
    gray_w_next  = bin2gray(bin_w_next);
    rd_bin_w     = gray2bin(rd_sync_w[G_SYNC_STAGES-1]);
    level_w_next = bin_w_next - rd_bin_w;
    // Full when the writer is exactly one lap ahead: top two gray bits differ.
    full_cmp     = {~rd_sync_w[G_SYNC_STAGES-1][AW:AW-1],
                    rd_sync_w[G_SYNC_STAGES-1][AW-2:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk_w or negedge i_arstN_w) begin
    if (!i_arstN_w) begin
      bin_w        <= '0;
      gray_w       <= '0;
      rd_sync_w    <= '0;
      o_full       <= 1'b0;
      o_afull_w    <= 1'b0;
      o_level_w    <= '0;
      o_overflow_w <= 1'b0;
    end else begin
      bin_w     <= bin_w_next;
      gray_w    <= gray_w_next;
      rd_sync_w <= {rd_sync_w[G_SYNC_STAGES-2:0], gray_r};
      o_full    <= (gray_w_next == full_cmp);
      o_level_w <= level_w_next;
      o_afull_w <= (level_w_next >= i_afull_thr_w);
      if (i_wren_w && o_full)
        o_overflow_w <= 1'b1;
      else if (i_ovf_clr_w)
        o_overflow_w <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries are
  // unreachable because the pointers are reset, and no reset keeps it a RAM.
  always_ff @(posedge i_clk_w) begin
    if (wr_acc) mem[bin_w[AW-1:0]] <= i_data_w;
  end

  // ---------------- read domain ----------------
  ptr_t bin_r_next, gray_r_next, wr_bin_r, level_r_next;
  logic [G_SYNC_STAGES-1:0][AW:0] wr_sync_r;
  logic rd_acc;

  always_comb begin
    rd_acc       = i_ren_r & ~o_empty;
    bin_r_next   = bin_r + {{AW{1'b0}}, rd_acc};
    gray_r_next  = bin2gray(bin_r_next);
    wr_bin_r     = gray2bin(wr_sync_r[G_SYNC_STAGES-1]);
    level_r_next = wr_bin_r - bin_r_next;
  end

  always_ff @(posedge i_clk_r or negedge i_arstN_r) begin
    if (!i_arstN_r) begin
      bin_r         <= '0;
      gray_r        <= '0;
      wr_sync_r     <= '0;
      o_empty       <= 1'b1;
      o_aempty_r    <= 1'b1;
      o_level_r     <= '0;
      o_underflow_r <= 1'b0;
      o_data        <= '0;
    end else begin
      bin_r      <= bin_r_next;
      gray_r     <= gray_r_next;
      wr_sync_r  <= {wr_sync_r[G_SYNC_STAGES-2:0], gray_w};
      o_empty    <= (gray_r_next == wr_sync_r[G_SYNC_STAGES-1]);
      o_level_r  <= level_r_next;
      o_aempty_r <= (level_r_next <= i_aempty_thr_r);
      if (rd_acc) o_data <= mem[bin_r[AW-1:0]];
      if (i_ren_r && o_empty)
        o_underflow_r <= 1'b1;
      else if (i_udf_clr_r)
        o_underflow_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed and randomised-stream bench for async_fifo_lvl (8-bit, 16 entries,
// 2-stage synchronisers); a queue models FIFO contents in the stream scenarios.
module tb_async_fifo_lvl;

  logic       clk_w = 1'b0, clk_r = 1'b0;
  logic       arst_n_w, arst_n_r;
  logic       wren, ovf_clr, ren, udf_clr;
  logic [7:0] data_w;
  logic [4:0] afull_thr, aempty_thr;
  logic       full, afull, overflow, empty, aempty, underflow;
  logic [4:0] level_w, level_r;
  logic [7:0] data_r;

  int half_w = 5, half_r = 5;
  int vec_cnt = 0, err_cnt = 0;
  logic [7:0] model_q[$];
  int bad_cnt;

  always #(half_w) clk_w = ~clk_w;
  always #(half_r) clk_r = ~clk_r;

  async_fifo_lvl #(.G_WIDTH(8), .G_DEPTH(4), .G_SYNC_STAGES(2)) dut (
    .i_clk_w(clk_w), .i_arstN_w(arst_n_w), .i_clk_r(clk_r), .i_arstN_r(arst_n_r),
    .i_wren_w(wren), .i_data_w(data_w), .i_afull_thr_w(afull_thr), .i_ovf_clr_w(ovf_clr),
    .o_full(full), .o_afull_w(afull), .o_level_w(level_w), .o_overflow_w(overflow),
    .i_ren_r(ren), .i_aempty_thr_r(aempty_thr), .i_udf_clr_r(udf_clr),
    .o_data(data_r), .o_empty(empty), .o_aempty_r(aempty), .o_level_r(level_r),
    .o_underflow_r(underflow)
  );

  task automatic wait_w(input int n);
    repeat (n) @(negedge clk_w);
  endtask

  task automatic wait_r(input int n);
    repeat (n) @(negedge clk_r);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk_w); wren = 1'b1; data_w = d;
    @(negedge clk_w); wren = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d);
    @(negedge clk_r); ren = 1'b1;
    @(negedge clk_r); ren = 1'b0; d = data_r;
  endtask

  task automatic test_reset;
    arst_n_w = 1'b0; arst_n_r = 1'b0;
    wren = 1'b0; ren = 1'b0; ovf_clr = 1'b0; udf_clr = 1'b0; data_w = '0;
    afull_thr = 5'd12; aempty_thr = 5'd2;
    wait_w(3);
    vec_cnt++;
    if ({full, afull, level_w, overflow} !== 8'b0) begin
      err_cnt++; $display("FAIL reset_wdom: got full=%b afull=%b lvl=%0d ovf=%b want 0/0/0/0",
                          full, afull, level_w, overflow);
    end
    vec_cnt++;
    if ({empty, aempty, level_r, underflow, data_r} !== {2'b11, 5'd0, 1'b0, 8'h00}) begin
      err_cnt++; $display("FAIL reset_rdom: got empty=%b aempty=%b lvl=%0d udf=%b data=%h want 1/1/0/0/00",
                          empty, aempty, level_r, underflow, data_r);
    end
    @(negedge clk_w) arst_n_w = 1'b1;
    @(negedge clk_r) arst_n_r = 1'b1;
    wait_w(2);
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_w); wren = 1'b1; data_w = 8'(i + 1);
    end
    @(negedge clk_w); wren = 1'b0;
    vec_cnt++;
    if (full !== 1'b1 || level_w !== 5'd16) begin
      err_cnt++; $display("FAIL fill_full: got full=%b lvl=%0d want 1/16", full, level_w);
    end
    wait_r(6);
    vec_cnt++;
    if (empty !== 1'b0 || level_r !== 5'd16) begin
      err_cnt++; $display("FAIL fill_rlevel: got empty=%b lvl=%0d want 0/16", empty, level_r);
    end
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk_r);
      if (i > 0) begin
        vec_cnt++;
        if (data_r !== 8'(i)) begin
          err_cnt++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_r, 8'(i));
        end
      end
      ren = (i < 16);
    end
    vec_cnt++;
    if (empty !== 1'b1 || level_r !== 5'd0) begin
      err_cnt++; $display("FAIL drain_empty: got empty=%b lvl=%0d want 1/0", empty, level_r);
    end
    wait_w(6);
    vec_cnt++;
    if (full !== 1'b0 || level_w !== 5'd0) begin
      err_cnt++; $display("FAIL full_release: got full=%b lvl=%0d want 0/0", full, level_w);
    end
  endtask

  task automatic test_thresholds;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      wr(8'h40 + 8'(i));
      if (i == 10) begin
        vec_cnt++;
        if (afull !== 1'b0) begin
          err_cnt++; $display("FAIL afull_at11: got %b want 0", afull);
        end
      end
    end
    vec_cnt++;
    if (afull !== 1'b1 || level_w !== 5'd12) begin
      err_cnt++; $display("FAIL afull_at12: got afull=%b lvl=%0d want 1/12", afull, level_w);
    end
    wait_r(6);
    vec_cnt++;
    if (aempty !== 1'b0 || level_r !== 5'd12) begin
      err_cnt++; $display("FAIL aempty_at12: got aempty=%b lvl=%0d want 0/12", aempty, level_r);
    end
    for (int i = 0; i < 9; i++) rd(d);
    vec_cnt++;
    if (aempty !== 1'b0 || level_r !== 5'd3 || d !== 8'h48) begin
      err_cnt++; $display("FAIL aempty_at3: got aempty=%b lvl=%0d d=%h want 0/3/48", aempty, level_r, d);
    end
    rd(d);
    vec_cnt++;
    if (aempty !== 1'b1 || level_r !== 5'd2 || d !== 8'h49) begin
      err_cnt++; $display("FAIL aempty_at2: got aempty=%b lvl=%0d d=%h want 1/2/49", aempty, level_r, d);
    end
    rd(d); rd(d);
    vec_cnt++;
    if (empty !== 1'b1 || d !== 8'h4B) begin
      err_cnt++; $display("FAIL thr_tail: got empty=%b d=%h want 1/4b", empty, d);
    end
    wait_w(6);
  endtask

  task automatic test_overflow_underflow;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
    wr(8'hAA);
    vec_cnt++;
    if (overflow !== 1'b1 || full !== 1'b1 || level_w !== 5'd16) begin
      err_cnt++; $display("FAIL ovf_set: got ovf=%b full=%b lvl=%0d want 1/1/16", overflow, full, level_w);
    end
    wait_w(3);
    vec_cnt++;
    if (overflow !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    ovf_clr = 1'b1; wr(8'hAA); ovf_clr = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    @(negedge clk_w) ovf_clr = 1'b1;
    @(negedge clk_w) ovf_clr = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    wait_r(6);
    for (int i = 0; i < 16; i++) begin
      rd(d);
      vec_cnt++;
      if (d !== 8'h30 + 8'(i)) begin
        err_cnt++; $display("FAIL ovf_contents[%0d]: got %h want %h", i, d, 8'h30 + 8'(i));
      end
    end
    rd(d);
    vec_cnt++;
    if (underflow !== 1'b1 || empty !== 1'b1 || d !== 8'h3F) begin
      err_cnt++; $display("FAIL udf_set: got udf=%b empty=%b data=%h want 1/1/3f", underflow, empty, d);
    end
    @(negedge clk_r) udf_clr = 1'b1;
    @(negedge clk_r) udf_clr = 1'b0;
    vec_cnt++;
    if (underflow !== 1'b0) begin
      err_cnt++; $display("FAIL udf_clear: got %b want 0", underflow);
    end
    udf_clr = 1'b1; rd(d); udf_clr = 1'b0;
    vec_cnt++;
    if (underflow !== 1'b1) begin
      err_cnt++; $display("FAIL udf_set_wins: got %b want 1", underflow);
    end
    @(negedge clk_r) udf_clr = 1'b1;
    @(negedge clk_r) udf_clr = 1'b0;
    wait_w(6);
  endtask

  // Concurrent producer/consumer; model_q holds words accepted but not yet read.
  task automatic run_stream(input string tag, input int n, input int wprob, input int rprob);
    int sent = 0, got = 0;
    int lim_w = n * 40 + 1000, lim_r = n * 40 + 1000;
    bad_cnt = 0;
    model_q.delete();
    fork
      begin
        int cyc = 0;
        while (sent < n && cyc < lim_w) begin
          @(negedge clk_w); cyc++;
          if (level_w > 5'd16 || model_q.size() > 16) bad_cnt++;
          wren   = ($urandom_range(99) < wprob);
          data_w = 8'($urandom);
          if (wren && !full) begin
            model_q.push_back(data_w); sent++;
          end
        end
        @(negedge clk_w); wren = 1'b0;
      end
      begin
        int cyc = 0;
        logic pend = 1'b0;
        logic [7:0] exp_d = '0;
        while ((got < n || pend) && cyc < lim_r) begin
          @(negedge clk_r); cyc++;
          if (level_r > 5'd16) bad_cnt++;
          if (pend) begin
            vec_cnt++;
            if (data_r !== exp_d) begin
              err_cnt++; $display("FAIL %s_data[%0d]: got %h want %h", tag, got, data_r, exp_d);
            end
            pend = 1'b0;
          end
          ren = (got < n) && ($urandom_range(99) < rprob);
          if (ren && !empty) begin
            if (model_q.size() == 0) bad_cnt++;
            else begin
              exp_d = model_q.pop_front(); pend = 1'b1;
            end
            got++;
          end
        end
        ren = 1'b0;
      end
    join
    vec_cnt++;
    if (sent != n || got != n) begin
      err_cnt++; $display("FAIL %s_timeout: got sent=%0d read=%0d want %0d", tag, sent, got, n);
    end
    vec_cnt++;
    if (bad_cnt != 0) begin
      err_cnt++; $display("FAIL %s_violations: got %0d want 0", tag, bad_cnt);
    end
    wait_r(6); wait_w(6);
    vec_cnt++;
    if (empty !== 1'b1 || full !== 1'b0 || level_w !== 5'd0 || level_r !== 5'd0) begin
      err_cnt++; $display("FAIL %s_settle: got empty=%b full=%b lw=%0d lr=%0d want 1/0/0/0",
                          tag, empty, full, level_w, level_r);
    end
    @(negedge clk_r) udf_clr = 1'b1;
    @(negedge clk_r) udf_clr = 1'b0;
  endtask

  task automatic test_wrap;
    run_stream("wrap", 100, 100, 100);
  endtask

  task automatic test_ratios;
    half_w = 5;  half_r = 17;
    run_stream("slow_rd", 3000, 50, 90);
    half_w = 17; half_r = 5;
    run_stream("slow_wr", 3000, 90, 50);
    half_w = 5;  half_r = 5;
    wait_w(4);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i));
    wait_r(6);
    rd(d);
    vec_cnt++;
    if (d !== 8'h60 || level_r !== 5'd7) begin
      err_cnt++; $display("FAIL pre_reset: got d=%h lvl=%0d want 60/7", d, level_r);
    end
    #3;
    arst_n_w = 1'b0; arst_n_r = 1'b0;
    #1;
    vec_cnt++;
    if ({empty, full, level_w, level_r, data_r, underflow} !== {2'b10, 10'd0, 8'h00, 1'b0}) begin
      err_cnt++; $display("FAIL mid_reset: got empty=%b full=%b lw=%0d lr=%0d data=%h udf=%b want 1/0/0/0/00/0",
                          empty, full, level_w, level_r, data_r, underflow);
    end
    wait_w(3);
    @(negedge clk_w) arst_n_w = 1'b1;
    @(negedge clk_r) arst_n_r = 1'b1;
    wait_w(2);
    wr(8'h5A);
    wait_r(6);
    vec_cnt++;
    if (empty !== 1'b0 || level_r !== 5'd1) begin
      err_cnt++; $display("FAIL post_reset_lvl: got empty=%b lvl=%0d want 0/1", empty, level_r);
    end
    rd(d);
    vec_cnt++;
    if (d !== 8'h5A || empty !== 1'b1) begin
      err_cnt++; $display("FAIL post_reset_rt: got d=%h empty=%b want 5a/1", d, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow_underflow();
    test_wrap();
    test_ratios();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
